// File: rtl/mcu_bus_router.sv
// mcu_bus_router: routes MCU byte frames to command targets, muxes replies back and aggregates masked IRQs.
// Define MCU_ROUTER_STATS_EN to add per-target frame counters readable through the status target.
module mcu_bus_router #(
  parameter int NUM_TGT = 4,
  parameter logic [23:0] TIMEOUT = 24'd1_000_000,
  parameter logic [7:0] STATUS_CODE = 8'h0F
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mcu_strobe,
  input  logic                   mcu_start,
  input  logic [7:0]             mcu_din,
  output logic [7:0]             mcu_dout,
  output logic [NUM_TGT-1:0]     tgt_strobe,
  output logic                   tgt_start,
  output logic [7:0]             tgt_din,
  input  logic [8*NUM_TGT-1:0]   tgt_dout,
  input  logic [NUM_TGT-1:0]     tgt_irq,
  output logic                   int_out_n
);
  localparam int SW = NUM_TGT > 1 ? $clog2(NUM_TGT) : 1;
  localparam logic [7:0] NT8 = 8'(NUM_TGT);
  typedef enum logic [2:0] {IDLE, SEL, FWD, STAT, DISCARD} state_t;
  state_t state;
  logic [7:0] sel, stat_cmd, err_cnt, stat_rd, reply, cnt_rd;
  logic [3:0] stat_idx;
  logic [23:0] wd;
  logic [NUM_TGT-1:0] irq_mask, pend;
  logic [SW-1:0] tsel;
  logic [7:0] ret [NUM_TGT];
  logic sel_byte;
  for (genvar i = 0; i < NUM_TGT; i++) begin : g_ret
    assign ret[i] = tgt_dout[8*i +: 8];
  end
  assign tsel = sel[SW-1:0];
  assign sel_byte = state == SEL && mcu_strobe && !mcu_start;
`ifdef MCU_ROUTER_STATS_EN
  logic [15:0] cnt [NUM_TGT];
  logic [7:0] cnt_b [16];
  for (genvar j = 0; j < 16; j++) begin : g_cb
    if (j < 2*NUM_TGT) begin : g_on
      assign cnt_b[j] = cnt[j/2][8*(j%2) +: 8];
    end else begin : g_off
      assign cnt_b[j] = 8'h00;
    end
  end
  assign cnt_rd = cnt_b[stat_idx];
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_TGT; i++)
      if (reset || (sel_byte && sel == STATUS_CODE && mcu_din == 8'd3)) cnt[i] <= '0;
      else if (sel_byte && sel == 8'(i)) cnt[i] <= cnt[i] + 16'd1;
`else
  assign cnt_rd = 8'h00;
`endif
  always_comb begin
    pend = tgt_irq & irq_mask;
    stat_rd = stat_idx == 4'd0 ? 8'(pend) : stat_idx == 4'd1 ? 8'(irq_mask) :
              stat_idx == 4'd2 ? err_cnt : stat_idx == 4'd3 ? NT8 : 8'h00;
    reply = stat_cmd == 8'd0 ? stat_rd : stat_cmd == 8'd2 ? cnt_rd : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel <= '0;
      stat_cmd <= '0;
      stat_idx <= '0;
      err_cnt <= '0;
      wd <= '0;
      irq_mask <= '1;
      mcu_dout <= '0;
      tgt_strobe <= '0;
      tgt_start <= 1'b0;
      tgt_din <= '0;
      int_out_n <= 1'b1;
    end else begin
      tgt_strobe <= '0;
      tgt_start <= 1'b0;
      int_out_n <= ~|(tgt_irq & irq_mask);
      wd <= (state == IDLE || mcu_strobe) ? '0 : wd + 24'd1;
      if (mcu_strobe && mcu_start) begin
        state <= SEL;
        sel <= mcu_din;
        mcu_dout <= '0;
      end else if (state != IDLE && !mcu_strobe && wd == TIMEOUT - 24'd1) begin
        state <= IDLE;
        mcu_dout <= '0;
        err_cnt <= err_cnt + {7'd0, err_cnt != 8'hFF};
      end else begin
        case (state)
          SEL: if (mcu_strobe) begin
            if (sel < NT8) begin
              state <= FWD;
              tgt_strobe <= NUM_TGT'(1) << tsel;
              tgt_din <= mcu_din;
              tgt_start <= 1'b1;
            end else if (sel == STATUS_CODE) begin
              state <= STAT;
              stat_cmd <= mcu_din;
              stat_idx <= '0;
            end else begin
              state <= DISCARD;
              mcu_dout <= 8'hFF;
            end
          end
          FWD: begin
            mcu_dout <= ret[tsel];
            if (mcu_strobe) begin
              tgt_strobe <= NUM_TGT'(1) << tsel;
              tgt_din <= mcu_din;
            end
          end
          STAT: if (mcu_strobe) begin
            mcu_dout <= reply;
            if (stat_cmd == 8'd1 && stat_idx == 4'd0) irq_mask <= mcu_din[NUM_TGT-1:0];
            stat_idx <= stat_idx == 4'd15 ? stat_idx : stat_idx + 4'd1;
          end
          DISCARD: mcu_dout <= 8'hFF;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mcu_bus_router.sv
// tb_mcu_bus_router: directed vector table, hand-written corner sequences and a randomized frame-level reference model.
module tb_mcu_bus_router;
  logic clk = 1'b0, reset = 1'b1, mcu_strobe = 1'b0, mcu_start = 1'b0;
  logic [7:0] mcu_din = 8'h00, mcu_dout, tgt_din;
  logic [3:0] tgt_strobe, tgt_irq = 4'h0;
  logic tgt_start, int_out_n;
  logic [31:0] tgt_dout = 32'h0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mcu_bus_router #(.NUM_TGT(4), .TIMEOUT(24'd100), .STATUS_CODE(8'h0F)) dut (
    .clk(clk), .reset(reset), .mcu_strobe(mcu_strobe), .mcu_start(mcu_start), .mcu_din(mcu_din),
    .mcu_dout(mcu_dout), .tgt_strobe(tgt_strobe), .tgt_start(tgt_start), .tgt_din(tgt_din),
    .tgt_dout(tgt_dout), .tgt_irq(tgt_irq), .int_out_n(int_out_n));

  typedef struct {
    logic st; logic [7:0] d; logic [3:0] irq;
    logic [3:0] stb; logic start; logic [7:0] din, dout; logic int_n;
  } vec_t;
  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // caller is at a negedge; returns at the negedge after the strobe edge
  task automatic send(input logic st, input logic [7:0] d);
    mcu_strobe = 1'b1; mcu_start = st; mcu_din = d;
    @(negedge clk);
    mcu_strobe = 1'b0; mcu_start = 1'b0;
  endtask

  // frame-level reference model
  int m_tgt, m_pos, k, gap;
  logic [7:0] m_cmd, m_dout, m_din, m_err, d;
  logic [3:0] m_mask, m_idx, e_stb;
  bit m_follow, st, e_start, e_int;
  logic [7:0] codes [7] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h0F, 8'h0F, 8'h09};
  logic [7:0] cmds [4] = '{8'h00, 8'h00, 8'h01, 8'h09};

  function automatic logic [7:0] lane(input int t);
    return tgt_dout[8*t +: 8];
  endfunction

  function automatic logic [7:0] stat_ref(input logic [3:0] idx);
    case (idx)
      4'd0: return {4'h0, tgt_irq & m_mask};
      4'd1: return {4'h0, m_mask};
      4'd2: return m_err;
      4'd3: return 8'd4;
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    tbl = '{
      '{1'b1, 8'h01, 4'h0, 4'h0, 1'b0, 8'h00, 8'h00, 1'b1},
      '{1'b0, 8'h04, 4'h0, 4'h2, 1'b1, 8'h04, 8'h00, 1'b1},
      '{1'b0, 8'h53, 4'h0, 4'h2, 1'b0, 8'h53, 8'h00, 1'b1},
      '{1'b0, 8'h02, 4'h0, 4'h2, 1'b0, 8'h02, 8'h00, 1'b1},
      '{1'b1, 8'h09, 4'h0, 4'h0, 1'b0, 8'h02, 8'h00, 1'b1},
      '{1'b0, 8'hAA, 4'h0, 4'h0, 1'b0, 8'h02, 8'hFF, 1'b1},
      '{1'b0, 8'hBB, 4'h0, 4'h0, 1'b0, 8'h02, 8'hFF, 1'b1},
      '{1'b1, 8'h0F, 4'h0, 4'h0, 1'b0, 8'h02, 8'h00, 1'b1},
      '{1'b0, 8'h01, 4'h0, 4'h0, 1'b0, 8'h02, 8'h00, 1'b1},
      '{1'b0, 8'h05, 4'h0, 4'h0, 1'b0, 8'h02, 8'h00, 1'b1},
      '{1'b1, 8'h0F, 4'h2, 4'h0, 1'b0, 8'h02, 8'h00, 1'b1},
      '{1'b0, 8'h00, 4'h4, 4'h0, 1'b0, 8'h02, 8'h00, 1'b0},
      '{1'b0, 8'h3C, 4'h4, 4'h0, 1'b0, 8'h02, 8'h04, 1'b0},
      '{1'b0, 8'h3C, 4'h4, 4'h0, 1'b0, 8'h02, 8'h05, 1'b0},
      '{1'b0, 8'h3C, 4'h4, 4'h0, 1'b0, 8'h02, 8'h00, 1'b0},
      '{1'b0, 8'h3C, 4'h4, 4'h0, 1'b0, 8'h02, 8'h04, 1'b0},
      '{1'b0, 8'h3C, 4'h4, 4'h0, 1'b0, 8'h02, 8'h00, 1'b0}};
    repeat (3) @(negedge clk);
    chk("rst_dout", mcu_dout, 8'h00);
    chk("rst_stb", tgt_strobe, 4'h0);
    chk("rst_start", tgt_start, 1'b0);
    chk("rst_din", tgt_din, 8'h00);
    chk("rst_int", int_out_n, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      tgt_irq = tbl[i].irq;
      send(tbl[i].st, tbl[i].d);
      chk($sformatf("tbl%0d_stb", i), tgt_strobe, tbl[i].stb);
      chk($sformatf("tbl%0d_start", i), tgt_start, tbl[i].start);
      chk($sformatf("tbl%0d_din", i), tgt_din, tbl[i].din);
      chk($sformatf("tbl%0d_dout", i), mcu_dout, tbl[i].dout);
      chk($sformatf("tbl%0d_int", i), int_out_n, tbl[i].int_n);
    end
    tgt_irq = 4'h0;
    // reply pipelining: the reply to byte k is seen when byte k+1 is clocked
    send(1'b1, 8'h00);
    send(1'b0, 8'h00);
    chk("rep_stb", tgt_strobe, 4'h1);
    tgt_dout = 32'h0000_005C;
    @(negedge clk);
    chk("rep_first", mcu_dout, 8'h5C);
    send(1'b0, 8'hE1);
    tgt_dout = 32'h0000_0042;
    @(negedge clk);
    chk("rep_second", mcu_dout, 8'h42);
    send(1'b0, 8'hE2);
    // watchdog: 99 idle clocks survive, 100 abort
    tgt_dout = 32'h0077_0000;
    send(1'b1, 8'h02);
    send(1'b0, 8'h10);
    chk("wd_stb0", tgt_strobe, 4'h4);
    repeat (99) @(negedge clk);
    chk("wd_dout_live", mcu_dout, 8'h77);
    send(1'b0, 8'h11);
    chk("wd_stb_99", tgt_strobe, 4'h4);
    chk("wd_din_99", tgt_din, 8'h11);
    repeat (100) @(negedge clk);
    chk("wd_dout_abort", mcu_dout, 8'h00);
    send(1'b0, 8'h22);
    chk("wd_idle_stb", tgt_strobe, 4'h0);
    send(1'b1, 8'h0F);
    send(1'b0, 8'h00);
    repeat (3) send(1'b0, 8'h00);
    chk("wd_err_cnt", mcu_dout, 8'h01);
    send(1'b1, 8'h01);
    send(1'b0, 8'h33);
    chk("wd_after_stb", tgt_strobe, 4'h2);
    chk("wd_after_start", tgt_start, 1'b1);
    chk("wd_after_din", tgt_din, 8'h33);
    tgt_dout = 32'h0;
    // start byte mid-forward
    send(1'b1, 8'h03);
    send(1'b0, 8'h44);
    chk("mid_stb_old", tgt_strobe, 4'h8);
    send(1'b1, 8'h01);
    chk("mid_start_nostb", tgt_strobe, 4'h0);
    send(1'b0, 8'h55);
    chk("mid_stb_new", tgt_strobe, 4'h2);
    chk("mid_start_flag", tgt_start, 1'b1);
    // reset mid-frame
    send(1'b1, 8'h0F);
    send(1'b0, 8'h01);
    send(1'b0, 8'h03);
    tgt_irq = 4'h1;
    send(1'b1, 8'h02);
    send(1'b0, 8'h66);
    chk("rstm_int_low", int_out_n, 1'b0);
    reset = 1'b1; mcu_strobe = 1'b1; mcu_din = 8'h77;
    @(negedge clk);
    mcu_strobe = 1'b0;
    chk("rstm_stb", tgt_strobe, 4'h0);
    chk("rstm_din", tgt_din, 8'h00);
    chk("rstm_int", int_out_n, 1'b1);
    tgt_irq = 4'h0;
    reset = 1'b0;
    send(1'b1, 8'h0F);
    send(1'b0, 8'h00);
    send(1'b0, 8'h00);
    send(1'b0, 8'h00);
    chk("rstm_mask", mcu_dout, 8'h0F);
    // randomized frames against the reference model
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_tgt = -1; m_pos = 0; m_dout = 8'h00; m_din = 8'h00; m_err = 8'h00;
    m_mask = 4'hF; m_idx = 4'h0; m_cmd = 8'h00; m_follow = 1'b0;
    for (int n = 0; n < 400; n++) begin
      st = m_tgt < 0 ? ($urandom_range(1) == 1) : ($urandom_range(4) == 0);
      k = $urandom_range(7);
      if (st) d = k == 7 ? 8'($urandom) : codes[k];
      else if (m_tgt == 15 && m_pos == 0) d = cmds[$urandom_range(3)];
      else d = 8'($urandom);
      tgt_irq = 4'($urandom);
      tgt_dout = $urandom;
      e_stb = 4'h0; e_start = 1'b0;
      e_int = !(|(tgt_irq & m_mask));
      if (st) begin
        m_tgt = int'(d); m_pos = 0; m_dout = 8'h00; m_follow = 1'b0;
      end else if (m_tgt >= 0) begin
        if (m_follow) m_dout = lane(m_tgt);
        m_pos++;
        if (m_tgt < 4) begin
          e_stb = 4'(1 << m_tgt); e_start = m_pos == 1; m_din = d; m_follow = 1'b1;
        end else if (m_tgt == 15) begin
          if (m_pos == 1) begin
            m_cmd = d; m_idx = 4'h0;
          end else begin
            m_dout = m_cmd == 8'h00 ? stat_ref(m_idx) : 8'h00;
            if (m_cmd == 8'h01 && m_idx == 4'h0) m_mask = d[3:0];
            if (m_idx != 4'hF) m_idx++;
          end
        end else m_dout = 8'hFF;
      end
      send(st, d);
      chk("rnd_stb", tgt_strobe, e_stb);
      chk("rnd_start", tgt_start, e_start);
      chk("rnd_din", tgt_din, m_din);
      chk("rnd_dout", mcu_dout, m_dout);
      chk("rnd_int", int_out_n, e_int);
      gap = $urandom_range(2);
      repeat (gap) begin
        @(negedge clk);
        if (m_follow) m_dout = lane(m_tgt);
        chk("rnd_gap_stb", tgt_strobe, 4'h0);
        chk("rnd_gap_dout", mcu_dout, m_dout);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
